pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, default 1023, number of consecutive stalled cycles that raises stall_timeout.
REQ-002 SHALL have parameter TO_W, default 10, width of the timeout counter; STALL_TIMEOUT fits in TO_W bits.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 stallreq_if / stallreq_id / stallreq_ex / stallreq_mem  in  1 each  stage stall requests.
REQ-006 excp_valid  in  1  exception committed in MEM; excp_target  in  32  handler entry PC.
REQ-007 ertn_valid  in  1  ertn committed in MEM; ertn_target  in  32  return PC.
REQ-008 stall  out  6  hold vector: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] wb.
REQ-009 flush  out  1  clear all pipeline registers this cycle.
REQ-010 new_pc_valid  out  1  redirect fetch; new_pc  out  32  redirect target.
REQ-011 llbit_clr  out  1  clear LLbit in the writeback LLbit register.
REQ-012 stall_timeout  out  1  sticky watchdog flag.

Function
REQ-013 FSM states SHALL be IDLE, FLUSH, RESUME.
REQ-014 IDLE: stall is combinational from requests, highest stage wins: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-015 IDLE with excp_valid or ertn_valid SHALL go to FLUSH next cycle; stall is 6'b000000 in that same cycle regardless of requests.
REQ-016 Simultaneous excp_valid and ertn_valid: exception wins, target excp_target.
REQ-017 FLUSH (exactly one cycle): flush=1, new_pc_valid=1, new_pc=latched target, llbit_clr=1 only if the cause was ertn; stall=0; then RESUME.
REQ-018 RESUME (exactly one cycle): flush=0, new_pc_valid=0, stall=0, stall requests ignored; then IDLE.
REQ-019 excp_valid/ertn_valid in FLUSH or RESUME SHALL be ignored.
REQ-020 flush, new_pc_valid, new_pc, llbit_clr SHALL be registered (one-cycle latency from the event); new_pc holds its last value when new_pc_valid=0.
REQ-021 Timeout counter increments each IDLE cycle with stall!=0, clears on any cycle with stall==0 or state!=IDLE, saturates at STALL_TIMEOUT.
REQ-022 stall_timeout sets in the cycle after the counter reaches STALL_TIMEOUT and stays set until reset.

Reset
REQ-023 Reset SHALL force state IDLE, flush=0, new_pc_valid=0, new_pc=32'h0, llbit_clr=0, stall_timeout=0, counter=0; stall=6'b000000 while reset is asserted.
REQ-024 Reset asserted mid-FLUSH SHALL suppress the pending redirect; no redirect after release.

Configuration
REQ-025 With PIPE_CTRL_PERF_EN defined: outputs perf_stall_cycles (32) counting IDLE cycles with stall!=0 and perf_flush_cnt (32) counting FLUSH entries, both reset to 0, wrap modulo 2^32.
REQ-026 Without PIPE_CTRL_PERF_EN: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-027 Stall-vector encodings, FSM state encodings and the 32-bit PC width SHALL live in the shared defines package.
REQ-028 Watchdog SHALL be one sub-module, stall_watchdog (counter, saturation, sticky flag).

Verification
REQ-029 stallreq_ex=1 alone, 3 cycles -> stall=6'b001111 each cycle, flush=0.
REQ-030 stallreq_if=1 and stallreq_mem=1 together -> stall=6'b011111.
REQ-031 excp_valid=1, excp_target=32'h1c008000 in cycle N -> cycle N+1 flush=1, new_pc_valid=1, new_pc=32'h1c008000, llbit_clr=0; N+2 RESUME all zero; N+3 IDLE.
REQ-032 excp_valid and ertn_valid both 1 with stallreq_mem=1 -> stall=0 that cycle, next cycle new_pc=excp_target, llbit_clr=0; ertn alone -> llbit_clr=1.
REQ-033 STALL_TIMEOUT=4, stallreq_id held -> stall_timeout=1 after 5th stalled cycle, remains 1 after request drops; reset clears it.
REQ-034 rst low during FLUSH -> outputs zero immediately, no new_pc_valid after release; with PIPE_CTRL_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: PC width, stall-vector encodings, FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned STALL_W = 6;

  // Hold vectors: bit 0 = pc ... bit 5 = wb; a stalled stage also holds every earlier stage.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_RESUME = 2'd2
  } pc_state_e;

  // Deepest requesting stage wins.
  function automatic logic [STALL_W-1:0] stall_encode(input logic req_if, input logic req_id,
                                                       input logic req_ex, input logic req_mem);
    logic [STALL_W-1:0] v;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    else             v = STALL_NONE;
    return v;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive stalled cycles, saturating at STALL_TIMEOUT, and raises a sticky timeout flag.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1023,
  parameter int unsigned TO_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic stall_timeout
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            flag_q;
  logic            hit;

  assign hit = (cnt_q == TO_W'(STALL_TIMEOUT));

  always_comb begin
    cnt_d = '0;
    if (stalled) cnt_d = hit ? cnt_q : cnt_q + TO_W'(1);
  end

  // Flag follows the counter hitting the limit by one cycle and never clears outside reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_q | hit;
    end
  end

  assign stall_timeout = flag_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stall vector, exception/ertn flush and fetch redirect.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1023,
  parameter int unsigned TO_W          = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               excp_valid,
  input  logic [PC_W-1:0]    excp_target,
  input  logic               ertn_valid,
  input  logic [PC_W-1:0]    ertn_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               new_pc_valid,
  output logic [PC_W-1:0]    new_pc,
  output logic               llbit_clr,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic               stall_timeout
);

  pc_state_e       state_q;
  logic            flush_q;
  logic            new_pc_valid_q;
  logic [PC_W-1:0] new_pc_q;
  logic            llbit_clr_q;
  logic            redirect;
  logic            stalled;

  assign redirect = excp_valid | ertn_valid;

  // Requests only matter in IDLE with no redirect pending; reset forces the vector to zero.
  always_comb begin
    stall = STALL_NONE;
    if (rst && (state_q == ST_IDLE) && !redirect)
      stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
  end

  assign stalled = (stall != STALL_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      flush_q        <= 1'b0;
      new_pc_valid_q <= 1'b0;
      new_pc_q       <= '0;
      llbit_clr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect) begin
            state_q        <= ST_FLUSH;
            flush_q        <= 1'b1;
            new_pc_valid_q <= 1'b1;
            new_pc_q       <= excp_valid ? excp_target : ertn_target;
            llbit_clr_q    <= ~excp_valid;
          end
        end
        ST_FLUSH: begin
          state_q        <= ST_RESUME;
          flush_q        <= 1'b0;
          new_pc_valid_q <= 1'b0;
          llbit_clr_q    <= 1'b0;
        end
        ST_RESUME: state_q <= ST_IDLE;
        default: begin
          state_q        <= ST_IDLE;
          flush_q        <= 1'b0;
          new_pc_valid_q <= 1'b0;
          llbit_clr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign flush        = flush_q;
  assign new_pc_valid = new_pc_valid_q;
  assign new_pc       = new_pc_q;
  assign llbit_clr    = llbit_clr_q;

  stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stalled       (stalled),
    .stall_timeout (stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stalled) perf_stall_q <= perf_stall_q + 32'd1;
      if ((state_q == ST_IDLE) && redirect) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall-vector table plus redirect, watchdog and reset sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, ertn_valid;
  logic [31:0] excp_target, ertn_target;
  logic [5:0]  stall;
  logic        flush, new_pc_valid, llbit_clr, stall_timeout;
  logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STALL_TIMEOUT(4), .TO_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_target   (excp_target),
    .ertn_valid    (ertn_valid),
    .ertn_target   (ertn_target),
    .stall         (stall),
    .flush         (flush),
    .new_pc_valid  (new_pc_valid),
    .new_pc        (new_pc),
    .llbit_clr     (llbit_clr),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_cnt    (perf_flush_cnt),
`endif
    .stall_timeout (stall_timeout)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] req;   // {mem, ex, id, if}
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'b0000, 6'b000000};
    vecs[1]  = '{4'b0001, 6'b000011};
    vecs[2]  = '{4'b0010, 6'b000111};
    vecs[3]  = '{4'b0100, 6'b001111};
    vecs[4]  = '{4'b0100, 6'b001111};
    vecs[5]  = '{4'b0100, 6'b001111};
    vecs[6]  = '{4'b1000, 6'b011111};
    vecs[7]  = '{4'b1001, 6'b011111};
    vecs[8]  = '{4'b0011, 6'b000111};
    vecs[9]  = '{4'b0110, 6'b001111};
    vecs[10] = '{4'b1111, 6'b011111};
    vecs[11] = '{4'b0000, 6'b000000};

    rst = 1'b0;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b1000;
    excp_valid = 1'b0; ertn_valid = 1'b0;
    excp_target = '0; ertn_target = '0;

    // Reset state, with a stall request present
    #3;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_npv", 32'(new_pc_valid), 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_llbit", 32'(llbit_clr), 32'h0);
    check("rst_timeout", 32'(stall_timeout), 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    check("rst_perf_stall", perf_stall_cycles, 32'h0);
    check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Stall encoding table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = vecs[i].req;
      #1;
      check($sformatf("tab%0d_stall", i), 32'(stall), 32'(vecs[i].exp));
      check($sformatf("tab%0d_flush", i), 32'(flush), 32'h0);
    end

    // Exception redirect; events in FLUSH/RESUME are ignored
    @(negedge clk);
    excp_valid = 1'b1; excp_target = 32'h1c008000; stallreq_mem = 1'b1;
    #1 check("excp_stall0", 32'(stall), 32'h0);
    @(negedge clk);
    excp_target = 32'hdead0000; stallreq_ex = 1'b1;
    #1;
    check("fl_flush", 32'(flush), 32'h1);
    check("fl_npv", 32'(new_pc_valid), 32'h1);
    check("fl_new_pc", new_pc, 32'h1c008000);
    check("fl_llbit", 32'(llbit_clr), 32'h0);
    check("fl_stall", 32'(stall), 32'h0);
    @(negedge clk);
    #1;
    check("rs_flush", 32'(flush), 32'h0);
    check("rs_npv", 32'(new_pc_valid), 32'h0);
    check("rs_stall", 32'(stall), 32'h0);
    check("rs_new_pc_hold", new_pc, 32'h1c008000);
    @(negedge clk);
    excp_valid = 1'b0; stallreq_mem = 1'b0;
    #1;
    check("idle_stall", 32'(stall), 32'h0f);
    check("idle_flush", 32'(flush), 32'h0);
    check("idle_npv", 32'(new_pc_valid), 32'h0);

    // Simultaneous exception and ertn: exception wins
    @(negedge clk);
    stallreq_ex = 1'b0;
    excp_valid = 1'b1; ertn_valid = 1'b1; stallreq_mem = 1'b1;
    excp_target = 32'h00001000; ertn_target = 32'h00002000;
    #1 check("both_stall0", 32'(stall), 32'h0);
    @(negedge clk);
    excp_valid = 1'b0; ertn_valid = 1'b0; stallreq_mem = 1'b0;
    #1;
    check("both_new_pc", new_pc, 32'h00001000);
    check("both_llbit", 32'(llbit_clr), 32'h0);
    check("both_npv", 32'(new_pc_valid), 32'h1);
    @(negedge clk);
    @(negedge clk);

    // ertn alone clears LLbit
    ertn_valid = 1'b1; ertn_target = 32'h00003000;
    @(negedge clk);
    ertn_valid = 1'b0;
    #1;
    check("ertn_llbit", 32'(llbit_clr), 32'h1);
    check("ertn_new_pc", new_pc, 32'h00003000);
    check("ertn_flush", 32'(flush), 32'h1);
    @(negedge clk);
    #1 check("ertn_llbit_rs", 32'(llbit_clr), 32'h0);
    @(negedge clk);

    // Watchdog with STALL_TIMEOUT=4
    rst = 1'b0;
    #1 check("wd_rst_clear", 32'(stall_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b1; stallreq_id = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      if (k == 4) check("wd_after4", 32'(stall_timeout), 32'h0);
      if (k == 5) check("wd_after5", 32'(stall_timeout), 32'h1);
    end
    stallreq_id = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("wd_sticky", 32'(stall_timeout), 32'h1);
    rst = 1'b0;
    #1 check("wd_reset", 32'(stall_timeout), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during FLUSH drops the redirect
    @(negedge clk);
    excp_valid = 1'b1; excp_target = 32'h0000abcd;
    @(negedge clk);
    excp_valid = 1'b0;
    #1 check("mf_flush_pre", 32'(flush), 32'h1);
    rst = 1'b0;
    #1;
    check("mf_flush", 32'(flush), 32'h0);
    check("mf_npv", 32'(new_pc_valid), 32'h0);
    check("mf_new_pc", new_pc, 32'h0);
    check("mf_llbit", 32'(llbit_clr), 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    check("mf_perf_stall", perf_stall_cycles, 32'h0);
    check("mf_perf_flush", perf_flush_cnt, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("mf_post%0d_npv", k), 32'(new_pc_valid), 32'h0);
      check($sformatf("mf_post%0d_flush", k), 32'(flush), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
